timer_counter: RTL
==================

# timer_counter

Memory-mapped programmable down-counter timer that sits on the system bridge and drives one hardware interrupt line into the coprocessor's `HWInt[2]` input. Software programs it through three word registers: CTRL, PRESET and COUNT. It counts down from PRESET and raises an interrupt request either once (mode 0) or periodically (mode 1). It is the upstream interrupt source that the exception unit samples every cycle.

## Interface
Parameters:
- none

Ports:
- `clk`  input  1  system clock; all state updates on rising edge
- `rst`  input  1  reset; **synchronous, active-high**
- `Addr`  input  2  word select (bus address bits [3:2]): 0 CTRL, 1 PRESET, 2 COUNT, 3 unused
- `WE`  input  1  write strobe for the selected register, sampled at the rising edge
- `DIn`  input  32  write data
- `DOut`  output  32  combinational read data for `Addr`
- `IRQ`  output  1  interrupt request to coprocessor `HWInt[2]`

## Operation
Registers:
- CTRL[3:0] = {IM, Mode[1:0], Enable}; bits [31:4] are not stored and read 0.
- Mode 00 selects one-shot; Mode 01 selects periodic; Modes 10 and 11 behave as 00.
- PRESET is 32-bit read/write.
- COUNT is 32-bit and read-only; writes to it are ignored.
- `DOut` by `Addr`: 0 returns {28'b0, CTRL}, 1 returns PRESET, 2 returns COUNT, 3 returns 0.

FSM states are IDLE, LOAD, CNT and INT:
- IDLE: COUNT holds its value. If Enable=1, go to LOAD.
- LOAD: COUNT <= PRESET. Go to CNT.
- CNT:
  - If Enable=0, go to IDLE with COUNT frozen.
  - Otherwise, if COUNT > 1, COUNT <= COUNT-1.
  - Otherwise, COUNT <= 0 and go to INT.
- INT:
  - Set internal flag `irq_f`.
  - Mode 0: clear Enable.
  - Mode 1: Enable is untouched.
  - Go to IDLE. In mode 1 IDLE then reloads immediately.

Interrupt output:
- `IRQ = IM & irq_f`.
- Mode 0: `irq_f` is sticky until any write to CTRL or PRESET clears it.
- Mode 1: `irq_f` stays high for exactly one cycle, then clears by itself.

Boundaries and simultaneous events:
- A bus write in the same cycle as an FSM update of CTRL (the Enable clear in INT) takes priority: the written value wins.
- Writing PRESET mid-count does not disturb COUNT. The new value applies at the next LOAD.
- Writing Enable=0 during CNT freezes COUNT. Re-enabling restarts from LOAD with a full reload, not a resume.
- PRESET=0 behaves like PRESET=1, giving the same interrupt timing.
- COUNT never underflows or wraps.
- IM=0 masks `IRQ` only. `irq_f` and the counting sequence still run.
- `rst` asserted in any state returns everything to reset values at that edge.

## Timing
- Reset values: CTRL=0, PRESET=0, COUNT=0, state=IDLE, `irq_f`=0, `IRQ`=0, `DOut`=0 for any Addr.
- Take edge E0 as the edge that writes Enable=1:
  - E1: enter LOAD.
  - E2: COUNT=N, enter CNT.
  - E(2+max(N,1)): COUNT=0, enter INT.
  - E(3+max(N,1)): `irq_f` set.
- `IRQ` is therefore high after max(N,1)+3 edges.
- Mode 1 period is max(N,1)+3 cycles between `IRQ` pulses.
- `DOut` is purely combinational from `Addr` and current register state. It has no read latency.
- Register writes are visible on `DOut` the cycle after the write edge.

## Configuration
- `TIMER_PERIODIC_EN` defined: Mode 01 gives periodic behaviour as described above.
- `TIMER_PERIODIC_EN` undefined:
  - Mode 01 behaves exactly as one-shot (Enable cleared in INT, `irq_f` sticky).
  - The Mode field remains readable and writable.

## Test plan
- Reset check: hold `rst` for 2 cycles, then read Addr 0/1/2 -> `DOut` = 0, 0, 0; `IRQ` = 0.
- One-shot: write PRESET=5, then CTRL=0x9 (IM=1, Mode 0, Enable=1) -> `IRQ` rises 8 edges after the CTRL write and stays high; CTRL reads 0x8; COUNT reads 0. Writing CTRL=0x8 drops `IRQ` the next cycle.
- Periodic (macro on): PRESET=3, CTRL=0xB -> `IRQ` one-cycle pulses every 6 cycles, first pulse 6 edges after the write. With the macro off, there is a single sticky `IRQ` and CTRL reads 0xA.
- Mask and disable:
  - CTRL=0x1 with PRESET=2 -> `IRQ` stays 0 while COUNT reaches 0.
  - Write Enable=0 when COUNT=1000 -> COUNT frozen at 1000 for 10 cycles.
- Collisions:
  - Write CTRL=0x9 on the INT-state edge -> Enable reads 1 afterwards.
  - Write COUNT=0x1234 -> ignored.
  - PRESET=0 -> `IRQ` after 4 edges.
- Reset mid-count: assert `rst` when COUNT=7 -> next cycle all registers 0, state IDLE, `IRQ` 0.

Source files
------------

// File: rtl/timer_counter_if.sv
// Bus-side signal bundle for timer_counter: word select, write strobe, data and interrupt line.
interface timer_counter_if;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] DIn;
    logic [31:0] DOut;
    logic        IRQ;

    modport master (
        output Addr,
        output WE,
        output DIn,
        input  DOut,
        input  IRQ
    );

    modport slave (
        input  Addr,
        input  WE,
        input  DIn,
        output DOut,
        output IRQ
    );
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped programmable down-counter timer (CTRL/PRESET/COUNT) with one-shot and periodic IRQ.
// Periodic mode is built only when TIMER_PERIODIC_EN is defined; otherwise mode 01 acts as one-shot.
module timer_counter (
    input  logic            clk,
    input  logic            rst,
    timer_counter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_f_q, irq_f_d;

    logic        wr_ctrl_s;
    logic        wr_preset_s;
    logic        periodic_s;
    logic        irq_set_s;

    assign wr_ctrl_s   = bus.WE && (bus.Addr == 2'd0);
    assign wr_preset_s = bus.WE && (bus.Addr == 2'd1);

`ifdef TIMER_PERIODIC_EN
    assign periodic_s = (ctrl_q[2:1] == 2'b01);
`else
    assign periodic_s = 1'b0;
`endif

    // Next-state, counter, control and interrupt-flag logic
    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        preset_d  = preset_q;
        count_d   = count_q;
        irq_f_d   = irq_f_q;
        irq_set_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_q[0]) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q[0]) begin
                    state_d = ST_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    // A preset of 0 lands here too, so it times exactly like 1
                    count_d = 32'd0;
                    state_d = ST_INT;
                end
            end
            ST_INT: begin
                irq_set_s = 1'b1;
                if (periodic_s) begin
                    ctrl_d = ctrl_q;
                end else begin
                    ctrl_d[0] = 1'b0;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A bus write overrides the FSM's own Enable clear in the same cycle
        if (wr_ctrl_s) begin
            ctrl_d = bus.DIn[3:0];
        end else begin
            ctrl_d = ctrl_d;
        end

        if (wr_preset_s) begin
            preset_d = bus.DIn;
        end else begin
            preset_d = preset_q;
        end

        // A new interrupt event is never lost to a coincident clearing write
        if (irq_set_s) begin
            irq_f_d = 1'b1;
        end else if (wr_ctrl_s || wr_preset_s) begin
            irq_f_d = 1'b0;
        end else if (periodic_s) begin
            irq_f_d = 1'b0;
        end else begin
            irq_f_d = irq_f_q;
        end
    end

    // State and register update with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= 4'd0;
            preset_q <= 32'd0;
            count_q  <= 32'd0;
            irq_f_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            irq_f_q  <= irq_f_d;
        end
    end

    // Zero-latency read mux
    always_comb begin
        case (bus.Addr)
            2'd0:    bus.DOut = {28'd0, ctrl_q};
            2'd1:    bus.DOut = preset_q;
            2'd2:    bus.DOut = count_q;
            default: bus.DOut = 32'd0;
        endcase
    end

    assign bus.IRQ = ctrl_q[3] & irq_f_q;

endmodule
